// File: rtl/fetch_ctrl_if.sv
// Instruction-side SRAM-like bus: one request/address phase, one data phase.
// The fetch sequencer is the master; the instruction memory is the slave.
interface fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: PC ownership, redirect arbitration, single-outstanding
// instruction bus, valid/stall handshake to decode. Optional macro: FETCH_ADDR_ERR_EN.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_REQ    | presenting pc on the bus, waiting for addr_ok
//   S_WAIT   | request accepted, waiting for data_ok
//   S_CANCEL | request accepted but stale; drop its data, then go to pending target
//   S_HOLD   | instruction held for decode until consumed or redirected
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
    parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         stall,
    input  logic         br_take,
    input  logic [31:0]  br_target,
    input  logic         exc_oc,
    input  logic         eret,
    input  logic [31:0]  epc,
    fetch_ctrl_if.master bus,
    output logic         if_valid,
    output logic [31:0]  if_pc,
    output logic [31:0]  if_inst,
    output logic         if_adel
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_CANCEL, S_HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pend_tgt, pend_tgt_nxt;
    logic        pend_vld, pend_vld_nxt;
    logic        if_valid_nxt;
    logic [31:0] if_pc_nxt, if_inst_nxt;
    logic        redir;
    logic [31:0] redir_tgt;

    always_comb begin
        redir = eret | exc_oc | br_take;
        if (eret)        redir_tgt = epc;
        else if (exc_oc) redir_tgt = EXC_ADDR;
        else             redir_tgt = br_target;
    end

`ifdef FETCH_ADDR_ERR_EN
    logic misalign;
    logic if_adel_r, if_adel_nxt;
    assign misalign     = |pc[1:0];
    assign bus.inst_req = resetn & (state == S_REQ) & ~misalign;
    assign if_adel      = if_adel_r;
`else
    assign bus.inst_req = resetn & (state == S_REQ);
    assign if_adel      = 1'b0;
`endif
    assign bus.inst_addr = {pc[31:2], 2'b00};

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_vld_nxt = pend_vld;
        pend_tgt_nxt = pend_tgt;
        if_valid_nxt = if_valid;
        if_pc_nxt    = if_pc;
        if_inst_nxt  = if_inst;
`ifdef FETCH_ADDR_ERR_EN
        if_adel_nxt  = if_adel_r;
`endif
        case (state)
            S_REQ: begin
`ifdef FETCH_ADDR_ERR_EN
                if (misalign) begin
                    if (redir) begin
                        pc_nxt = redir_tgt;
                    end else begin
                        state_nxt    = S_HOLD;
                        if_valid_nxt = 1'b1;
                        if_adel_nxt  = 1'b1;
                        if_pc_nxt    = pc;
                        if_inst_nxt  = '0;
                    end
                end else
`endif
                begin
                    // the request in flight stays on the bus; the redirect waits in pend_*
                    if (redir) begin
                        pend_vld_nxt = 1'b1;
                        pend_tgt_nxt = redir_tgt;
                    end
                    if (bus.inst_addr_ok)
                        state_nxt = (pend_vld | redir) ? S_CANCEL : S_WAIT;
                end
            end
            S_WAIT: begin
                if (redir) begin
                    if (bus.inst_data_ok) begin
                        pc_nxt    = redir_tgt;
                        state_nxt = S_REQ;
                    end else begin
                        pend_vld_nxt = 1'b1;
                        pend_tgt_nxt = redir_tgt;
                        state_nxt    = S_CANCEL;
                    end
                end else if (bus.inst_data_ok) begin
                    if_valid_nxt = 1'b1;
                    if_pc_nxt    = pc;
                    if_inst_nxt  = bus.inst_rdata;
`ifdef FETCH_ADDR_ERR_EN
                    if_adel_nxt  = 1'b0;
`endif
                    state_nxt    = S_HOLD;
                end
            end
            S_CANCEL: begin
                if (redir) pend_tgt_nxt = redir_tgt;
                if (bus.inst_data_ok) begin
                    pc_nxt       = redir ? redir_tgt : pend_tgt;
                    pend_vld_nxt = 1'b0;
                    state_nxt    = S_REQ;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    if_valid_nxt = 1'b0;
                    pc_nxt       = redir_tgt;
                    state_nxt    = S_REQ;
                end else if (!stall) begin
                    if_valid_nxt = 1'b0;
                    pc_nxt       = if_pc + 32'd4;
                    state_nxt    = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_REQ;
            pc        <= RESET_ADDR;
            pend_vld  <= 1'b0;
            pend_tgt  <= '0;
            if_valid  <= 1'b0;
            if_pc     <= '0;
            if_inst   <= '0;
`ifdef FETCH_ADDR_ERR_EN
            if_adel_r <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_tgt  <= pend_tgt_nxt;
            if_valid  <= if_valid_nxt;
            if_pc     <= if_pc_nxt;
            if_inst   <= if_inst_nxt;
`ifdef FETCH_ADDR_ERR_EN
            if_adel_r <= if_adel_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed literal scenarios followed by randomized bus/redirect
// traffic, all checked every cycle against a flag-based transaction model.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_A = 32'hbfc0_0000;
    localparam logic [31:0] EXC_A = 32'hbfc0_0380;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        stall = 1'b0;
    logic        br_take = 1'b0;
    logic        exc_oc = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] br_target = '0;
    logic [31:0] epc = '0;
    logic        if_valid, if_adel;
    logic [31:0] if_pc, if_inst;

    fetch_ctrl_if bus();

    fetch_ctrl #(.RESET_ADDR(RST_A), .EXC_ADDR(EXC_A)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .stall     (stall),
        .br_take   (br_take),
        .br_target (br_target),
        .exc_oc    (exc_oc),
        .eret      (eret),
        .epc       (epc),
        .bus       (bus),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .if_adel   (if_adel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction model: next fetch address, whether a fetch is outstanding, whether a
    // redirect has made the current fetch stale, and the instruction held for decode.
    logic [31:0] m_pc, m_tgt, m_hpc, m_hinst;
    logic        m_stale, m_out, m_held, m_adel;
    logic        s_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RST_A; m_tgt = '0; m_hpc = '0; m_hinst = '0;
        m_stale = 1'b0; m_out = 1'b0; m_held = 1'b0; m_adel = 1'b0;
    endtask

    task automatic model_step();
        logic        r;
        logic [31:0] t;
        r = eret | exc_oc | br_take;
        t = eret ? epc : (exc_oc ? EXC_A : br_target);
        if (m_held) begin
            if (r) begin
                m_held = 1'b0; m_pc = t;
            end else if (!stall) begin
                m_held = 1'b0; m_pc = m_hpc + 32'd4;
            end
        end else if (!m_out) begin
`ifdef FETCH_ADDR_ERR_EN
            if (m_pc[1:0] != 2'b00) begin
                if (r) m_pc = t;
                else begin
                    m_held = 1'b1; m_adel = 1'b1; m_hpc = m_pc; m_hinst = '0;
                end
            end else
`endif
            begin
                if (r) begin m_stale = 1'b1; m_tgt = t; end
                if (bus.inst_addr_ok) m_out = 1'b1;
            end
        end else begin
            if (r) begin m_stale = 1'b1; m_tgt = t; end
            if (bus.inst_data_ok) begin
                m_out = 1'b0;
                if (m_stale) begin
                    m_pc = m_tgt; m_stale = 1'b0;
                end else begin
                    m_held = 1'b1; m_adel = 1'b0; m_hpc = m_pc; m_hinst = bus.inst_rdata;
                end
            end
        end
    endtask

    task automatic compare();
        logic exp_req;
        if (!resetn) begin
            chk("reset inst_req", bus.inst_req, 0);
            chk("reset inst_addr", bus.inst_addr, RST_A);
            chk("reset if_valid", if_valid, 0);
            chk("reset if_pc", if_pc, 0);
            chk("reset if_inst", if_inst, 0);
            chk("reset if_adel", if_adel, 0);
        end else begin
            exp_req = !m_held && !m_out;
`ifdef FETCH_ADDR_ERR_EN
            exp_req = exp_req && (m_pc[1:0] == 2'b00);
`endif
            chk("inst_req", bus.inst_req, exp_req);
            if (exp_req) chk("inst_addr", bus.inst_addr, {m_pc[31:2], 2'b00});
            chk("if_valid", if_valid, m_held);
            if (m_held) begin
                chk("if_pc", if_pc, m_hpc);
                chk("if_inst", if_inst, m_hinst);
            end
            chk("if_adel", if_adel, m_held & m_adel);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] v;
        v = $urandom();
        if ($urandom_range(0, 7) != 0) v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = '0;
        s_out = 1'b0;
        model_reset();
        fork
            forever begin
                @(posedge clk);
                if (!resetn) model_reset();
                else         model_step();
                #1;
                compare();
            end
            begin
                bit did_rst;
                did_rst = 1'b0;
                // reset values and first fetch
                repeat (3) tick();
                #1;
                chk("t1 rst inst_req", bus.inst_req, 0);
                chk("t1 rst inst_addr", bus.inst_addr, RST_A);
                chk("t1 rst if_valid", if_valid, 0);
                resetn = 1'b1;
                #1;
                chk("t1 first req", bus.inst_req, 1);
                chk("t1 first addr", bus.inst_addr, 32'hbfc0_0000);
                bus.inst_addr_ok = 1'b1;
                tick();
                bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h2400_0001;
                tick();
                bus.inst_data_ok = 1'b0;
                chk("t1 if_valid", if_valid, 1);
                chk("t1 if_pc", if_pc, 32'hbfc0_0000);
                chk("t1 if_inst", if_inst, 32'h2400_0001);
                tick();
                chk("t1 next req", bus.inst_req, 1);
                chk("t1 next addr", bus.inst_addr, 32'hbfc0_0004);

                // branch while waiting for data: that data must be dropped
                bus.inst_addr_ok = 1'b1;
                tick();
                bus.inst_addr_ok = 1'b0; br_take = 1'b1; br_target = 32'hbfc0_0100;
                tick();
                br_take = 1'b0;
                tick();
                tick();
                bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'hdead_beef;
                tick();
                bus.inst_data_ok = 1'b0;
                chk("t2 dropped valid", if_valid, 0);
                chk("t2 req", bus.inst_req, 1);
                chk("t2 addr", bus.inst_addr, 32'hbfc0_0100);

                // eret + exception together in HOLD under stall: eret wins
                bus.inst_addr_ok = 1'b1;
                tick();
                bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h1111_2222;
                tick();
                bus.inst_data_ok = 1'b0;
                chk("t3 held valid", if_valid, 1);
                stall = 1'b1; eret = 1'b1; epc = 32'h8000_0010; exc_oc = 1'b1;
                tick();
                eret = 1'b0; exc_oc = 1'b0; stall = 1'b0;
                chk("t3 dropped valid", if_valid, 0);
                chk("t3 req", bus.inst_req, 1);
                chk("t3 addr", bus.inst_addr, 32'h8000_0010);

                // four stalled cycles in HOLD, then release
                bus.inst_addr_ok = 1'b1;
                tick();
                bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h3333_4444;
                tick();
                bus.inst_data_ok = 1'b0; stall = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    tick();
                    chk("t4 valid", if_valid, 1);
                    chk("t4 pc", if_pc, 32'h8000_0010);
                    chk("t4 inst", if_inst, 32'h3333_4444);
                    chk("t4 no req", bus.inst_req, 0);
                end
                stall = 1'b0;
                tick();
                chk("t4 next addr", bus.inst_addr, 32'h8000_0014);

                // slow addr_ok with a branch in the middle
                for (int k = 1; k <= 5; k++) begin
                    bus.inst_addr_ok = (k == 5);
                    br_take = (k == 2);
                    br_target = 32'hbfc0_0200;
                    #1;
                    chk("t5 req", bus.inst_req, 1);
                    chk("t5 addr stable", bus.inst_addr, 32'h8000_0014);
                    tick();
                end
                bus.inst_addr_ok = 1'b0; br_take = 1'b0;
                chk("t5 cancel no req", bus.inst_req, 0);
                bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h5555_6666;
                tick();
                bus.inst_data_ok = 1'b0;
                chk("t5 dropped valid", if_valid, 0);
                chk("t5 addr", bus.inst_addr, 32'hbfc0_0200);

`ifdef FETCH_ADDR_ERR_EN
                // misaligned branch target raises an address error without a bus request
                bus.inst_addr_ok = 1'b1;
                tick();
                bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h7777_8888;
                tick();
                bus.inst_data_ok = 1'b0;
                stall = 1'b1; br_take = 1'b1; br_target = 32'hbfc0_0102;
                tick();
                br_take = 1'b0; stall = 1'b0;
                #1;
                chk("t6 no req", bus.inst_req, 0);
                tick();
                chk("t6 valid", if_valid, 1);
                chk("t6 adel", if_adel, 1);
                chk("t6 pc", if_pc, 32'hbfc0_0102);
                chk("t6 inst", if_inst, 0);
                br_take = 1'b1; br_target = 32'hbfc0_0300;
                tick();
                br_take = 1'b0;
                chk("t6 recover addr", bus.inst_addr, 32'hbfc0_0300);
`endif
                bus.inst_addr_ok = 1'b1;
                tick();
                bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b1; bus.inst_rdata = 32'h9999_aaaa;
                tick();
                bus.inst_data_ok = 1'b0;
                tick();

                // randomized traffic with one reset while a fetch is outstanding
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (!did_rst && i >= 1000 && s_out) begin
                        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0;
                        br_take = 1'b0; exc_oc = 1'b0; eret = 1'b0; stall = 1'b0;
                        resetn = 1'b0;
                        repeat (2) @(negedge clk);
                        resetn = 1'b1;
                        did_rst = 1'b1;
                    end
                    stall     = ($urandom_range(0, 9) < 4);
                    br_take   = ($urandom_range(0, 11) == 0);
                    exc_oc    = ($urandom_range(0, 11) == 0);
                    eret      = ($urandom_range(0, 11) == 0);
                    br_target = rand_tgt();
                    epc       = rand_tgt();
                    #1;
                    bus.inst_addr_ok = bus.inst_req && !s_out && ($urandom_range(0, 1) == 1);
                    bus.inst_data_ok = s_out && ($urandom_range(0, 9) < 4);
                    bus.inst_rdata   = $urandom();
                    @(posedge clk);
                    if (bus.inst_addr_ok)      s_out = 1'b1;
                    else if (bus.inst_data_ok) s_out = 1'b0;
                end
                @(negedge clk);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
        join
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the IF stage.
- Owns the PC, arbitrates the redirect sources (eret, exception, branch) against sequential advance, and drives the SRAM-like instruction bus with a single outstanding request.
- Cancels in-flight fetches that a redirect has made stale.
- Presents a valid/stall handshake to the decode stage.

Parameters:
- RESET_ADDR, 32'hbfc0_0000, first fetch address after reset
- EXC_ADDR, 32'hbfc0_0380, exception entry address

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, asynchronous, active-low
- stall  in  1  1: decode cannot accept this cycle
- br_take  in  1  redirect fetch to br_target
- br_target  in  32  branch target
- exc_oc  in  1  exception; redirect to EXC_ADDR
- eret  in  1  redirect to epc
- epc  in  32  eret return address
- inst_req  out  1  bus request
- inst_addr  out  32  bus address
- inst_addr_ok  in  1  address accepted
- inst_data_ok  in  1  read data returned
- inst_rdata  in  32  read data
- if_valid  out  1  if_pc/if_inst valid to decode
- if_pc  out  32  PC of delivered instruction
- if_inst  out  32  delivered instruction
- if_adel  out  1  address-error flag (optional feature only; otherwise constant 0)

Behaviour:
- Reset (async, resetn=0):
  - state=REQ, pc=RESET_ADDR, pending redirect cleared.
  - inst_req=0, inst_addr=RESET_ADDR, if_valid=0, if_pc=0, if_inst=0, if_adel=0.
- Redirect arbitration:
  - Priority eret > exc_oc > br_take; target = epc / EXC_ADDR / br_target.
  - A redirect is sampled every cycle in every state.
- States:
  - REQ: inst_req=1, inst_addr=pc.
    - Address held stable until inst_addr_ok.
    - A redirect in REQ is latched as pending; the current request is not withdrawn.
    - On addr_ok: goto CANCEL if a redirect is pending or arrives this cycle, else WAIT.
  - WAIT: inst_req=0.
    - On data_ok with no redirect: capture if_pc=pc, if_inst=inst_rdata; if_valid=1 next cycle; goto HOLD.
    - Redirect without data_ok: latch target, goto CANCEL.
    - Redirect with data_ok in the same cycle: data dropped, pc=target, goto REQ.
  - CANCEL: inst_req=0; wait for data_ok, discard it, then pc=pending target, clear pending, goto REQ.
    - A newer redirect in CANCEL overwrites the pending target.
  - HOLD: if_valid=1.
    - Consumption (if_valid & !stall): pc=if_pc+4 (wrap modulo 2^32), goto REQ, if_valid=0 next cycle.
    - Redirect in HOLD with stall=1: held instruction dropped (if_valid=0 next cycle), pc=target, goto REQ.
    - Redirect in HOLD with stall=0: instruction counts as consumed, then pc=target instead of +4.
- Latency:
  - First inst_req=1 in the first cycle after resetn deasserts.
  - Minimum fetch-to-valid: addr_ok cycle → data_ok in a later cycle → if_valid the cycle after data_ok.
- Bus rules:
  - Never more than one outstanding request.
  - inst_req never asserted while in WAIT/CANCEL.
- Reset mid-transaction: all state cleared immediately; a data_ok arriving after reset release with no request outstanding is ignored.

Optional Feature:
- FETCH_ADDR_ERR_EN defined:
  - In REQ, a pc with pc[1:0]!=0 issues no bus request.
  - Goes directly to HOLD with if_adel=1, if_pc=pc, if_inst=0.
  - Consumption or redirect proceeds as in normal HOLD.
- Undefined:
  - if_adel tied 0.
  - inst_addr driven with pc[1:0] forced to 2'b00.

Test Plan:
- Release reset, addr_ok same cycle, data_ok 1 cycle later with 32'h2400_0001, stall=0 → inst_addr=bfc0_0000; if_valid with if_pc=bfc0_0000, if_inst=2400_0001; next req addr bfc0_0004.
- br_take=1, br_target=bfc0_0100 in WAIT, data_ok 3 cycles later → that data not delivered; next inst_req addr=bfc0_0100.
- eret (epc=8000_0010) and exc_oc in the same cycle in HOLD with stall=1 → held inst dropped; next inst_addr=8000_0010.
- stall=1 for 4 cycles in HOLD → if_valid/if_pc/if_inst stable, inst_req=0 throughout; release → next addr=if_pc+4.
- addr_ok delayed 5 cycles with br_take pulsed in cycle 2 → inst_addr unchanged until addr_ok; following data dropped; then fetch at br_target.
- With FETCH_ADDR_ERR_EN, br_target=bfc0_0102 → no inst_req; if_valid=1, if_adel=1, if_pc=bfc0_0102.
